avalon_to_ssram_bridge: RTL and testbench

Avalon-MM burst slave that converts system-side read/write bursts into single-command SSRAM transactions for the SSRAM-to-HyperRAM controller. It sits directly upstream of that controller and drives its SSRAM port (CS/OE/WE, address, address spacing, burstcount, write data). It consumes read data via validout and write-data backpressure via haltdata/busy. Write bursts are fully buffered before the SSRAM command is issued, so the controller never sees a data underrun.

---
 rtl/avalon_to_ssram_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_avalon_to_ssram_bridge.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_to_ssram_bridge.sv
// Avalon-MM burst slave that turns bursts into single SSRAM commands for the HyperRAM controller.
// Optional read watchdog enabled by defining SSRAM_TIMEOUT_EN.
module avalon_to_ssram_bridge #(
    parameter int MAX_BURST = 64,
    parameter int BW        = 7,
    parameter int TIMEOUT   = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   avs_address,
    input  logic [BW-1:0] avs_burstcount,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [15:0]   avs_writedata,
    output logic          avs_waitrequest,
    output logic [15:0]   avs_readdata,
    output logic          avs_readdatavalid,
    output logic          SSRAM_CS,
    output logic          SSRAM_OE,
    output logic          SSRAM_WE,
    output logic          SSRAM_address_spacing,
    output logic [31:0]   SSRAM_address,
    output logic [10:0]   SSRAM_burstcount,
    output logic [15:0]   SSRAM_in,
    input  logic [15:0]   SSRAM_out,
    input  logic          SSRAM_validout,
    input  logic          SSRAM_busy,
    input  logic          SSRAM_haltdata,
    output logic          bridge_error
);

    // state   | meaning
    // IDLE    | ready for a new Avalon command once the controller is not busy
    // WR_FILL | collecting the remaining write beats into the FIFO
    // WR_CMD  | write command strobe (CS+WE) to the controller
    // WR_DATA | streaming FIFO words, paced by haltdata
    // RD_CMD  | read command strobe (CS+OE) to the controller
    // RD_DATA | forwarding validout beats to the Avalon side
    // DRAIN   | CS released, waiting for the controller to go idle
    typedef enum logic [2:0] {
        IDLE, WR_FILL, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DRAIN
    } state_t;

    localparam int AW = $clog2(MAX_BURST);

    state_t        state;
    logic [15:0]   fifo_mem [MAX_BURST];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [BW-1:0] burst_len;
    logic [BW-1:0] beats_left;
    logic [BW-1:0] eff_bc;
    logic          push;

`ifdef SSRAM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;
    logic          flush;
`endif

    assign avs_waitrequest = !(((state == IDLE) && !SSRAM_busy) || (state == WR_FILL));
    assign eff_bc          = (avs_burstcount == '0) ? BW'(1) : avs_burstcount;
    assign push            = ((state == IDLE) && !SSRAM_busy && avs_write) ||
                             ((state == WR_FILL) && avs_write);
    assign rd_ptr_nxt      = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= avs_writedata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            burst_len             <= '0;
            beats_left            <= '0;
            avs_readdata          <= '0;
            avs_readdatavalid     <= 1'b0;
            SSRAM_CS              <= 1'b0;
            SSRAM_OE              <= 1'b0;
            SSRAM_WE              <= 1'b0;
            SSRAM_address_spacing <= 1'b0;
            SSRAM_address         <= '0;
            SSRAM_burstcount      <= '0;
            SSRAM_in              <= '0;
            bridge_error          <= 1'b0;
`ifdef SSRAM_TIMEOUT_EN
            tmr                   <= '0;
            flush                 <= 1'b0;
`endif
        end else begin
            avs_readdatavalid <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            // stray read data is dropped but remembered
            if (SSRAM_validout && (state != RD_DATA))
                bridge_error <= 1'b1;

            case (state)
                IDLE: begin
                    if (!SSRAM_busy && (avs_write || avs_read)) begin
                        SSRAM_address_spacing <= avs_address[31];
                        SSRAM_address         <= {1'b0, avs_address[30:0]};
                        SSRAM_burstcount      <= {{(11-BW){1'b0}}, eff_bc};
                        burst_len             <= eff_bc;
                        if (avs_write) begin
                            if (avs_read)
                                bridge_error <= 1'b1;
                            if (eff_bc == BW'(1)) begin
                                state    <= WR_CMD;
                                SSRAM_CS <= 1'b1;
                                SSRAM_WE <= 1'b1;
                            end else begin
                                beats_left <= eff_bc - 1'b1;
                                state      <= WR_FILL;
                            end
                        end else begin
                            beats_left <= eff_bc;
                            state      <= RD_CMD;
                            SSRAM_CS   <= 1'b1;
                            SSRAM_OE   <= 1'b1;
                        end
                    end
                end
                WR_FILL: begin
                    if (avs_write) begin
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BW'(1)) begin
                            state    <= WR_CMD;
                            SSRAM_CS <= 1'b1;
                            SSRAM_WE <= 1'b1;
                        end
                    end
                end
                WR_CMD: begin
                    SSRAM_WE   <= 1'b0;
                    SSRAM_in   <= fifo_mem[rd_ptr];
                    beats_left <= burst_len;
                    state      <= WR_DATA;
                end
                WR_DATA: begin
                    // SSRAM_in always mirrors the FIFO head; advance it on each consumed word
                    if (!SSRAM_haltdata) begin
                        rd_ptr     <= rd_ptr_nxt;
                        SSRAM_in   <= fifo_mem[rd_ptr_nxt];
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BW'(1)) begin
                            state    <= DRAIN;
                            SSRAM_CS <= 1'b0;
                        end
                    end
                end
                RD_CMD: begin
                    SSRAM_OE <= 1'b0;
                    state    <= RD_DATA;
`ifdef SSRAM_TIMEOUT_EN
                    tmr      <= TW'(TIMEOUT);
                    flush    <= 1'b0;
`endif
                end
                RD_DATA: begin
`ifdef SSRAM_TIMEOUT_EN
                    if (flush) begin
                        avs_readdata      <= 16'hDEAD;
                        avs_readdatavalid <= 1'b1;
                        beats_left        <= beats_left - 1'b1;
                        if (beats_left == BW'(1)) begin
                            state    <= DRAIN;
                            SSRAM_CS <= 1'b0;
                            flush    <= 1'b0;
                        end
                    end else if (SSRAM_validout) begin
                        avs_readdata      <= SSRAM_out;
                        avs_readdatavalid <= 1'b1;
                        beats_left        <= beats_left - 1'b1;
                        tmr               <= TW'(TIMEOUT);
                        if (beats_left == BW'(1)) begin
                            state    <= DRAIN;
                            SSRAM_CS <= 1'b0;
                        end
                    end else if (tmr == '0) begin
                        flush        <= 1'b1;
                        bridge_error <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
`else
                    if (SSRAM_validout) begin
                        avs_readdata      <= SSRAM_out;
                        avs_readdatavalid <= 1'b1;
                        beats_left        <= beats_left - 1'b1;
                        if (beats_left == BW'(1)) begin
                            state    <= DRAIN;
                            SSRAM_CS <= 1'b0;
                        end
                    end
`endif
                end
                DRAIN: begin
                    if (!SSRAM_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_to_ssram_bridge.sv
// Directed self-checking bench for avalon_to_ssram_bridge.
// Covers writes with haltdata, reads, full-depth bursts, async reset and error flag.
module tb_avalon_to_ssram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] avs_address;
    logic [6:0]  avs_burstcount;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic        avs_waitrequest;
    logic [15:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        SSRAM_CS;
    logic        SSRAM_OE;
    logic        SSRAM_WE;
    logic        SSRAM_address_spacing;
    logic [31:0] SSRAM_address;
    logic [10:0] SSRAM_burstcount;
    logic [15:0] SSRAM_in;
    logic [15:0] SSRAM_out;
    logic        SSRAM_validout;
    logic        SSRAM_busy;
    logic        SSRAM_haltdata;
    logic        bridge_error;

    int checks = 0;
    int errors = 0;
    logic [15:0] got [128];

    always #5 clk = ~clk;

    avalon_to_ssram_bridge dut (
        .clk                   (clk),
        .rst                   (rst),
        .avs_address           (avs_address),
        .avs_burstcount        (avs_burstcount),
        .avs_read              (avs_read),
        .avs_write             (avs_write),
        .avs_writedata         (avs_writedata),
        .avs_waitrequest       (avs_waitrequest),
        .avs_readdata          (avs_readdata),
        .avs_readdatavalid     (avs_readdatavalid),
        .SSRAM_CS              (SSRAM_CS),
        .SSRAM_OE              (SSRAM_OE),
        .SSRAM_WE              (SSRAM_WE),
        .SSRAM_address_spacing (SSRAM_address_spacing),
        .SSRAM_address         (SSRAM_address),
        .SSRAM_burstcount      (SSRAM_burstcount),
        .SSRAM_in              (SSRAM_in),
        .SSRAM_out             (SSRAM_out),
        .SSRAM_validout        (SSRAM_validout),
        .SSRAM_busy            (SSRAM_busy),
        .SSRAM_haltdata        (SSRAM_haltdata),
        .bridge_error          (bridge_error)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives a write burst, counting cycles the bridge stalled it.
    task automatic send_write(input logic [31:0] addr, input int n, input logic [6:0] bc,
                              input logic [15:0] base, input logic [15:0] step, output int stalls);
        stalls = 0;
        avs_address    = addr;
        avs_burstcount = bc;
        for (int i = 0; i < n; i++) begin
            avs_write     = 1'b1;
            avs_writedata = base + 16'(i) * step;
            while (avs_waitrequest && stalls < 200) begin
                stalls++;
                tick();
            end
            tick();
        end
        avs_write = 1'b0;
    endtask

    // Plays the controller in the data phase; haltdata high for cycles [hs, hs+hl).
    task automatic drain_data(input int hs, input int hl, output int cycles, output int nwords);
        cycles = 0;
        nwords = 0;
        while (SSRAM_CS && !SSRAM_WE && cycles < 300) begin
            SSRAM_haltdata = (cycles >= hs) && (cycles < hs + hl);
            if (!SSRAM_haltdata && nwords < 128) begin
                got[nwords] = SSRAM_in;
                nwords++;
            end
            cycles++;
            tick();
        end
        SSRAM_haltdata = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (avs_waitrequest && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (avs_waitrequest) begin
            errors++;
            $display("FAIL %s: bridge did not return to idle within 50 cycles", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        SSRAM_busy = 1'b1;
        #1;
        checks++;
        if (avs_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_waitreq_busy: got %b want 1", avs_waitrequest);
        end
        checks++;
        if ({SSRAM_CS, SSRAM_OE, SSRAM_WE, SSRAM_address_spacing, avs_readdatavalid, bridge_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {SSRAM_CS, SSRAM_OE, SSRAM_WE, SSRAM_address_spacing, avs_readdatavalid, bridge_error});
        end
        checks++;
        if ({SSRAM_address, SSRAM_burstcount, SSRAM_in, avs_readdata} !== 75'b0) begin
            errors++;
            $display("FAIL reset_fields: addr %h bc %h in %h rd %h want all 0",
                     SSRAM_address, SSRAM_burstcount, SSRAM_in, avs_readdata);
        end
        tick();
        rst = 1'b0;
        SSRAM_busy = 1'b0;
        #1;
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_waitreq_idle: got %b want 0", avs_waitrequest);
        end
        tick();
    endtask

    task automatic test_single_write;
        int stalls;
        send_write(32'h0000_0010, 1, 7'd1, 16'hA5A5, 16'h0, stalls);
        checks++;
        if ({SSRAM_CS, SSRAM_WE, SSRAM_OE} !== 3'b110) begin
            errors++;
            $display("FAIL sw_cmd: CS/WE/OE got %b want 110", {SSRAM_CS, SSRAM_WE, SSRAM_OE});
        end
        checks++;
        if (SSRAM_address !== 32'h10 || SSRAM_burstcount !== 11'd1 || SSRAM_address_spacing !== 1'b0) begin
            errors++;
            $display("FAIL sw_fields: addr %h bc %0d sp %b want 10 1 0",
                     SSRAM_address, SSRAM_burstcount, SSRAM_address_spacing);
        end
        tick();
        checks++;
        if (SSRAM_CS !== 1'b1 || SSRAM_WE !== 1'b0 || SSRAM_in !== 16'hA5A5) begin
            errors++;
            $display("FAIL sw_data: CS %b WE %b in %h want 1 0 a5a5", SSRAM_CS, SSRAM_WE, SSRAM_in);
        end
        SSRAM_busy = 1'b1;
        tick();
        checks++;
        if (SSRAM_CS !== 1'b0 || avs_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL sw_drain: CS %b waitreq %b want 0 1", SSRAM_CS, avs_waitrequest);
        end
        tick();
        SSRAM_busy = 1'b0;
        #1;
        checks++;
        if (avs_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL sw_drain_comb: waitreq %b want 1 while still in drain", avs_waitrequest);
        end
        tick();
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL sw_idle: waitreq %b want 0", avs_waitrequest);
        end
    endtask

    task automatic test_halt_write;
        int stalls, cycles, nwords;
        send_write(32'h0000_0200, 8, 7'd8, 16'h1000, 16'h1, stalls);
        checks++;
        if (stalls !== 0 || SSRAM_WE !== 1'b1 || SSRAM_burstcount !== 11'd8) begin
            errors++;
            $display("FAIL hw_cmd: stalls %0d WE %b bc %0d want 0 1 8", stalls, SSRAM_WE, SSRAM_burstcount);
        end
        tick();
        drain_data(3, 3, cycles, nwords);
        checks++;
        if (cycles !== 11 || nwords !== 8) begin
            errors++;
            $display("FAIL hw_len: cycles %0d words %0d want 11 8", cycles, nwords);
        end
        for (int i = 0; i < 8 && i < nwords; i++) begin
            checks++;
            if (got[i] !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL hw_word%0d: got %h want %h", i, got[i], 16'h1000 + 16'(i));
            end
        end
        wait_idle("hw_idle");
    endtask

    task automatic test_read;
        logic [3:0] vpat = 4'b0;
        int pulses = 0;
        logic [15:0] nxt = 16'hB000;
        logic prev_v = 1'b0;
        logic [15:0] prev_d = 16'h0;
        logic [5:0] pattern;
        pattern = 6'b101101;
        avs_address    = 32'h8000_0004;
        avs_burstcount = 7'd4;
        avs_read       = 1'b1;
        tick();
        avs_read = 1'b0;
        checks++;
        if ({SSRAM_CS, SSRAM_OE, SSRAM_WE} !== 3'b110) begin
            errors++;
            $display("FAIL rd_cmd: CS/OE/WE got %b want 110", {SSRAM_CS, SSRAM_OE, SSRAM_WE});
        end
        checks++;
        if (SSRAM_address_spacing !== 1'b1 || SSRAM_address !== 32'h4 || SSRAM_burstcount !== 11'd4) begin
            errors++;
            $display("FAIL rd_fields: sp %b addr %h bc %0d want 1 4 4",
                     SSRAM_address_spacing, SSRAM_address, SSRAM_burstcount);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            SSRAM_validout = pattern[c];
            SSRAM_out      = nxt;
            prev_v = SSRAM_validout;
            prev_d = nxt;
            if (pattern[c]) nxt = nxt + 16'h0011;
            tick();
            SSRAM_validout = 1'b0;
            checks++;
            if (avs_readdatavalid !== prev_v || (prev_v && avs_readdata !== prev_d)) begin
                errors++;
                $display("FAIL rd_beat%0d: valid %b data %h want %b %h",
                         c, avs_readdatavalid, avs_readdata, prev_v, prev_d);
            end
            if (avs_readdatavalid) pulses++;
        end
        vpat = 4'(pulses);
        checks++;
        if (vpat !== 4'd4 || SSRAM_CS !== 1'b0 || bridge_error !== 1'b0) begin
            errors++;
            $display("FAIL rd_end: pulses %0d CS %b err %b want 4 0 0", vpat, SSRAM_CS, bridge_error);
        end
        wait_idle("rd_idle");
    endtask

    task automatic test_max_burst;
        int stalls, cycles, nwords, bad;
        bad = -1;
        send_write(32'h0000_1000, 64, 7'd64, 16'h5A00, 16'h0007, stalls);
        checks++;
        if (stalls !== 0 || SSRAM_WE !== 1'b1 || SSRAM_burstcount !== 11'd64) begin
            errors++;
            $display("FAIL max_fill: stalls %0d WE %b bc %0d want 0 1 64", stalls, SSRAM_WE, SSRAM_burstcount);
        end
        tick();
        drain_data(0, 0, cycles, nwords);
        for (int i = 63; i >= 0; i--)
            if (i < nwords && got[i] !== 16'h5A00 + 16'(i) * 16'h0007) bad = i;
        checks++;
        if (cycles !== 64 || nwords !== 64 || bad !== -1) begin
            errors++;
            $display("FAIL max_order: cycles %0d words %0d first bad index %0d want 64 64 -1",
                     cycles, nwords, bad);
        end
        wait_idle("max_idle");
    endtask

    task automatic test_reset_mid;
        int stalls;
        send_write(32'h0000_0300, 8, 7'd8, 16'h2000, 16'h1, stalls);
        tick();
        SSRAM_haltdata = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({SSRAM_CS, SSRAM_WE, SSRAM_OE} !== 3'b0 || SSRAM_in !== 16'h0 ||
            SSRAM_address !== 32'h0 || SSRAM_burstcount !== 11'd0 || avs_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: CS/WE/OE %b in %h addr %h bc %0d waitreq %b want 000 0 0 0 0",
                     {SSRAM_CS, SSRAM_WE, SSRAM_OE}, SSRAM_in, SSRAM_address, SSRAM_burstcount, avs_waitrequest);
        end
        tick();
        rst = 1'b0;
        tick();
        send_write(32'h0000_0044, 1, 7'd1, 16'h7E7E, 16'h0, stalls);
        checks++;
        if (SSRAM_WE !== 1'b1 || SSRAM_address !== 32'h44) begin
            errors++;
            $display("FAIL rm_next_cmd: WE %b addr %h want 1 44", SSRAM_WE, SSRAM_address);
        end
        tick();
        checks++;
        if (SSRAM_in !== 16'h7E7E) begin
            errors++;
            $display("FAIL rm_next_data: in %h want 7e7e", SSRAM_in);
        end
        tick();
        wait_idle("rm_idle");
    endtask

    task automatic test_errors;
        int stalls;
        checks++;
        if (bridge_error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", bridge_error);
        end
        SSRAM_validout = 1'b1;
        SSRAM_out      = 16'h3333;
        tick();
        SSRAM_validout = 1'b0;
        checks++;
        if (bridge_error !== 1'b1 || avs_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL err_stray_valid: err %b rdvalid %b want 1 0", bridge_error, avs_readdatavalid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        avs_read = 1'b1;
        send_write(32'h0000_0050, 1, 7'd0, 16'h4242, 16'h0, stalls);
        avs_read = 1'b0;
        checks++;
        if (bridge_error !== 1'b1 || SSRAM_WE !== 1'b1 || SSRAM_OE !== 1'b0 || SSRAM_burstcount !== 11'd1) begin
            errors++;
            $display("FAIL err_rw_conflict: err %b WE %b OE %b bc %0d want 1 1 0 1",
                     bridge_error, SSRAM_WE, SSRAM_OE, SSRAM_burstcount);
        end
        tick();
        checks++;
        if (SSRAM_in !== 16'h4242) begin
            errors++;
            $display("FAIL err_rw_data: in %h want 4242", SSRAM_in);
        end
        tick();
        wait_idle("err_idle");
    endtask

`ifdef SSRAM_TIMEOUT_EN
    task automatic test_timeout;
        int dead = 0;
        int n = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        avs_address    = 32'h0000_0080;
        avs_burstcount = 7'd4;
        avs_read       = 1'b1;
        tick();
        avs_read = 1'b0;
        tick();
        SSRAM_validout = 1'b1;
        SSRAM_out      = 16'h1234;
        tick();
        SSRAM_validout = 1'b0;
        while (SSRAM_CS && n < 3000) begin
            tick();
            n++;
            if (avs_readdatavalid && avs_readdata === 16'hDEAD) dead++;
        end
        checks++;
        if (dead !== 3 || bridge_error !== 1'b1 || SSRAM_CS !== 1'b0) begin
            errors++;
            $display("FAIL timeout: dead beats %0d err %b CS %b want 3 1 0", dead, bridge_error, SSRAM_CS);
        end
        wait_idle("to_idle");
    endtask
`endif

    initial begin
        rst            = 1'b1;
        avs_address    = '0;
        avs_burstcount = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        SSRAM_out      = '0;
        SSRAM_validout = 1'b0;
        SSRAM_busy     = 1'b1;
        SSRAM_haltdata = 1'b0;
        test_reset();
        test_single_write();
        test_halt_write();
        test_read();
        test_max_burst();
        test_reset_mid();
        test_errors();
`ifdef SSRAM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
